// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronise and de-glitch the bus, deframe 11-bit frames,
// fold E0/F0 prefixes into key events and queue them in a first-word-fall-through FIFO.
module ps2_rx_fifo #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET,
  input  logic                          PS2_KBCLK,
  input  logic                          PS2_KBDAT,
  input  logic                          evt_ready,
  output logic                          evt_valid,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_break,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic [15:0]                   led
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FiltMax = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TmoMax  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] Full    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Bit 0 carries the PS/2 clock, bit 1 the PS/2 data.
  logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
  logic [FW-1:0] fcnt_q [2];
  logic [FW-1:0] fcnt_d [2];
  logic fclk_prev_q, fclk_prev_d, strobe, fdat;

  state_e state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d, byte_q, byte_d;
  logic par_ok_q, par_ok_d, byte_vld_q, byte_vld_d;
  logic perr_q, perr_d, ferr_q, ferr_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic ext_q, ext_d, brk_q, brk_d, push;
  logic [9:0] mem_q [FIFO_DEPTH];
  logic [9:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, pop, do_push;
  logic [15:0] led_q, led_d;

  always_comb begin
    sync1_d = {PS2_KBDAT, PS2_KBCLK};
    sync2_d = sync1_q;
    filt_d  = filt_q;
    fcnt_d  = fcnt_q;
    // Count consecutive samples that disagree with the filtered level.
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == FiltMax) begin
        filt_d[i] = sync2_q[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + FW'(1);
      end
    end
    fclk_prev_d = filt_q[0];
  end

  assign strobe = fclk_prev_q & ~filt_q[0];
  assign fdat   = filt_q[1];

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_d     = byte_q;
    par_ok_d   = par_ok_q;
    tmo_d      = tmo_q;
    byte_vld_d = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    if (strobe) begin
      tmo_d = '0;
      unique case (state_q)
        StIdle: begin
          if (!fdat) begin
            state_d   = StData;
            bit_idx_d = 3'd0;
          end
        end
        StData: begin
          shift_d   = {fdat, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_ok_d = ^{shift_q, fdat};
          perr_d   = ~par_ok_d;
          state_d  = StStop;
        end
        StStop: begin
          if (fdat && par_ok_q) begin
            byte_vld_d = 1'b1;
            byte_d     = shift_q;
          end else if (!fdat) begin
            ferr_d = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      if (tmo_q == TmoMax) begin
        ferr_d  = 1'b1;
        tmo_d   = '0;
        state_d = StIdle;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    push  = 1'b0;
    if (perr_q || ferr_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld_q) begin
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_comb begin
    pop      = (cnt_q != '0) && evt_ready;
    do_push  = push && ((cnt_q != Full) || pop);
    ovf_d    = ovf_q | (push && !do_push);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    led_d    = led_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = {ext_q, brk_q, byte_q};
      wr_ptr_d        = wr_ptr_q + AW'(1);
      led_d           = brk_q ? 16'h0000 : {(ext_q ? 8'hE0 : 8'h00), byte_q};
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !pop) cnt_d = cnt_q + CW'(1);
    else if (pop && !do_push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      filt_q      <= 2'b11;
      fcnt_q      <= '{default: '0};
      fclk_prev_q <= 1'b1;
      state_q     <= StIdle;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      byte_q      <= 8'h00;
      par_ok_q    <= 1'b0;
      byte_vld_q  <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      tmo_q       <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      led_q       <= 16'h0000;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      fclk_prev_q <= fclk_prev_d;
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      byte_q      <= byte_d;
      par_ok_q    <= par_ok_d;
      byte_vld_q  <= byte_vld_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      tmo_q       <= tmo_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      led_q       <= led_d;
    end
  end

  assign evt_valid  = (cnt_q != '0);
  assign evt_ext    = mem_q[rd_ptr_q][9];
  assign evt_break  = mem_q[rd_ptr_q][8];
  assign evt_code   = mem_q[rd_ptr_q][7:0];
  assign evt_count  = cnt_q;
  assign overflow   = ovf_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign led        = led_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed scenarios plus random key streams, checked against a
// frame-level model of the decoder and event queue.
module tb_ps2_rx_fifo;

  localparam int D = 4;
  localparam int H = 20;  // PS/2 half bit period in CLOCK_50 cycles

  logic clk = 1'b0;
  logic rst, kbclk, kbdat, ready;
  logic evt_valid, evt_ext, evt_break, overflow, parity_err, frame_err;
  logic [7:0] evt_code;
  logic [2:0] evt_count;
  logic [15:0] led;

  always #10 clk = ~clk;

  ps2_rx_fifo #(
    .FIFO_DEPTH    (D),
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .CLOCK_50  (clk),
    .RESET     (rst),
    .PS2_KBCLK (kbclk),
    .PS2_KBDAT (kbdat),
    .evt_ready (ready),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_break (evt_break),
    .evt_count (evt_count),
    .overflow  (overflow),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .led       (led)
  );

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;

  ev_t         q[$];
  logic        m_ext, m_brk, m_ovf;
  logic [15:0] m_led;
  int          exp_perr, exp_ferr;
  int          perr_cnt = 0;
  int          ferr_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(negedge clk) begin
    if (parity_err) perr_cnt++;
    if (frame_err) ferr_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    kbdat = b;
    wait_cyc(H);
    kbclk = 1'b0;
    wait_cyc(H);
    kbclk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
    kbdat = 1'b1;
    wait_cyc(3 * H);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    if (bad_par || bad_stop) begin
      if (bad_par) exp_perr++;
      else exp_ferr++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (q.size() < D) begin
        q.push_back({m_ext, m_brk, b});
        m_led = m_brk ? 16'h0000 : {(m_ext ? 8'hE0 : 8'h00), b};
      end else begin
        m_ovf = 1'b1;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_frame(b, bad_par, bad_stop, 11);
    model_frame(b, bad_par, bad_stop);
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "/count"}, evt_count, q.size());
    check_eq({tag, "/valid"}, evt_valid, q.size() != 0);
    check_eq({tag, "/overflow"}, overflow, m_ovf);
    check_eq({tag, "/led"}, led, m_led);
    check_eq({tag, "/parity_pulses"}, perr_cnt, exp_perr);
    check_eq({tag, "/frame_pulses"}, ferr_cnt, exp_ferr);
    if (q.size() != 0) check_eq({tag, "/head"}, {evt_ext, evt_break, evt_code}, q[0]);
  endtask

  task automatic pop_one(input string tag);
    check_eq({tag, "/pop_valid"}, evt_valid, 1'b1);
    check_eq({tag, "/pop_event"}, {evt_ext, evt_break, evt_code}, q[0]);
    ready = 1'b1;
    wait_cyc(1);
    ready = 1'b0;
    void'(q.pop_front());
    wait_cyc(2);
  endtask

  task automatic model_reset();
    q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_ovf = 1'b0;
    m_led = 16'h0000;
  endtask

  initial begin
    logic [7:0] b;
    int r;
    rst = 1'b1;
    kbclk = 1'b1;
    kbdat = 1'b1;
    ready = 1'b0;
    exp_perr = 0;
    exp_ferr = 0;
    model_reset();
    wait_cyc(5);
    check_state("reset");
    check_eq("reset/code", evt_code, 8'h00);
    rst = 1'b0;
    wait_cyc(5);

    frame(8'h1C, 1'b0, 1'b0);
    check_state("make_1c");
    check_eq("make_1c/led_const", led, 16'h001C);
    pop_one("make_1c");

    ready = 1'b1;
    wait_cyc(5);
    ready = 1'b0;
    check_eq("ready_when_empty/count", evt_count, 0);

    frame(8'hE0, 1'b0, 1'b0);
    frame(8'h75, 1'b0, 1'b0);
    check_state("ext_make");
    check_eq("ext_make/led_const", led, 16'hE075);
    frame(8'hE0, 1'b0, 1'b0);
    frame(8'hF0, 1'b0, 1'b0);
    frame(8'h75, 1'b0, 1'b0);
    check_state("ext_break");
    check_eq("ext_break/led_const", led, 16'h0000);
    pop_one("ext_make");
    pop_one("ext_break");

    frame(8'h1C, 1'b1, 1'b0);
    check_state("bad_parity");
    frame(8'h1C, 1'b0, 1'b0);
    check_state("after_parity");
    pop_one("after_parity");

    frame(8'h15, 1'b0, 1'b0);
    frame(8'h1D, 1'b0, 1'b0);
    frame(8'h24, 1'b0, 1'b0);
    frame(8'h2D, 1'b0, 1'b0);
    frame(8'h2C, 1'b0, 1'b0);
    check_state("overflow");
    check_eq("overflow/count_const", evt_count, 4);
    for (int i = 0; i < 4; i++) pop_one("drain");
    check_state("drained");

    frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 5);
    wait_cyc(1100);
    exp_ferr++;
    m_ext = 1'b0;
    m_brk = 1'b0;
    check_state("timeout");
    frame(8'h29, 1'b0, 1'b0);
    check_state("after_timeout");
    pop_one("after_timeout");

    frame(8'hE0, 1'b0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    kbdat = 1'b0;
    wait_cyc(H);
    kbclk = 1'b0;
    wait_cyc(H / 2);
    rst = 1'b1;
    #1;
    model_reset();
    check_state("mid_reset");
    check_eq("mid_reset/code", evt_code, 8'h00);
    kbclk = 1'b1;
    kbdat = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2 * H);
    frame(8'h75, 1'b0, 1'b0);
    check_state("after_reset");
    pop_one("after_reset");

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r < 2) b = 8'hE0;
      else if (r == 2) b = 8'hF0;
      else if (r == 3) b = 8'hE1;
      else b = 8'($urandom_range(1, 127));
      r = $urandom_range(0, 7);
      frame(b, r == 0, r == 1);
      check_state("random");
      r = $urandom_range(0, 2);
      for (int k = 0; k < r; k++) begin
        if (q.size() != 0) pop_one("random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
